// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared RAM controller widths and round-robin encoding
package ram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 2;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_t;

endpackage

// File: rtl/ram_conflict_arb.sv
// rtl/ram_conflict_arb.sv - two-client arbiter in front of the dual-port RAM
module ram_conflict_arb
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    output logic                  we1,
    output logic                  oe1,
    output logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] d_in1,
    input  logic [DATA_WIDTH-1:0] d_out1,

    output logic                  we2,
    output logic                  oe2,
    output logic [ADDR_WIDTH-1:0] addr2,
    output logic [DATA_WIDTH-1:0] d_in2,
    input  logic [DATA_WIDTH-1:0] d_out2,

    output logic [CNT_WIDTH-1:0]  stall_cnt_a,
    output logic [CNT_WIDTH-1:0]  stall_cnt_b
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    rr_t  rr_last;
    rr_t  winner;
    logic conflict;

    // Two reads of one address are safe on the RAM, so only a write makes it a conflict.
    always_comb begin
        conflict = req_a & req_b & (addr_a == addr_b) & (we_a | we_b);
        winner   = (rr_last == RR_A) ? RR_B : RR_A;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        if (!rst) begin
            gnt_a = req_a & (~conflict | (winner == RR_A));
            gnt_b = req_b & (~conflict | (winner == RR_B));
        end
    end

    assign we1   = req_a & gnt_a & we_a;
    assign oe1   = req_a & gnt_a & ~we_a;
    assign addr1 = addr_a;
    assign d_in1 = wdata_a;

    assign we2   = req_b & gnt_b & we_b;
    assign oe2   = req_b & gnt_b & ~we_b;
    assign addr2 = addr_b;
    assign d_in2 = wdata_b;

    // The RAM registers its read data, so d_out is already aligned with rvalid.
    assign rdata_a = d_out1;
    assign rdata_b = d_out2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last     <= RR_B;
            rvalid_a    <= 1'b0;
            rvalid_b    <= 1'b0;
            stall_cnt_a <= '0;
            stall_cnt_b <= '0;
        end else begin
            rvalid_a <= gnt_a & ~we_a;
            rvalid_b <= gnt_b & ~we_b;
            if (conflict) begin
                rr_last <= winner;
                if (winner == RR_B && stall_cnt_a != CNT_MAX)
                    stall_cnt_a <= stall_cnt_a + 1'b1;
                if (winner == RR_A && stall_cnt_b != CNT_MAX)
                    stall_cnt_b <= stall_cnt_b + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_conflict_arb.sv
// tb/tb_ram_conflict_arb.sv - self-checking bench for ram_conflict_arb
module tb_ram_conflict_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [3:0] addr_a, addr_b;
    logic [1:0] wdata_a, wdata_b;
    logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
    logic [1:0] rdata_a, rdata_b;
    logic       we1, oe1, we2, oe2;
    logic [3:0] addr1, addr2;
    logic [1:0] d_in1, d_out1, d_in2, d_out2;
    logic [7:0] stall_cnt_a, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    ram_conflict_arb dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .we1(we1), .oe1(oe1), .addr1(addr1), .d_in1(d_in1), .d_out1(d_out1),
        .we2(we2), .oe2(oe2), .addr2(addr2), .d_in2(d_in2), .d_out2(d_out2),
        .stall_cnt_a(stall_cnt_a), .stall_cnt_b(stall_cnt_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with registered read data.
    logic [1:0] mem [16];
    always @(posedge clk) begin
        if (oe1) d_out1 <= mem[addr1];
        if (we1) mem[addr1] <= d_in1;
        if (oe2) d_out2 <= mem[addr2];
        if (we2) mem[addr2] <= d_in2;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {grant_a, grant_b} from the arbitration rules.
    function automatic logic [1:0] exp_grants(input logic r, input logic ra, input logic wa,
                                              input logic [3:0] aa, input logic rb,
                                              input logic wb, input logic [3:0] ab,
                                              input int last_winner);
        logic conf;
        if (r) return 2'b00;
        conf = ra && rb && (aa == ab) && (wa || wb);
        if (!conf) return {ra, rb};
        return (last_winner == 1) ? 2'b10 : 2'b01;
    endfunction

    int         m_rr;
    int         m_sa, m_sb;
    logic       m_rva, m_rvb;
    logic [1:0] m_rda, m_rdb;
    logic [1:0] model_mem [16];

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        logic       conf;
        if (rst) begin
            m_rr  = 1;
            m_sa  = 0;
            m_sb  = 0;
            m_rva = 1'b0;
            m_rvb = 1'b0;
        end else begin
            g     = exp_grants(1'b0, req_a, we_a, addr_a, req_b, we_b, addr_b, m_rr);
            conf  = req_a && req_b && (addr_a == addr_b) && (we_a || we_b);
            m_rva = g[1] && !we_a;
            m_rvb = g[0] && !we_b;
            if (m_rva) m_rda = model_mem[addr_a];
            if (m_rvb) m_rdb = model_mem[addr_b];
            if (g[1] && we_a) model_mem[addr_a] = wdata_a;
            if (g[0] && we_b) model_mem[addr_b] = wdata_b;
            if (conf) begin
                if (g[1]) m_sb = (m_sb < 255) ? m_sb + 1 : 255;
                else      m_sa = (m_sa < 255) ? m_sa + 1 : 255;
                m_rr = g[1] ? 0 : 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] g;
        g = exp_grants(rst, req_a, we_a, addr_a, req_b, we_b, addr_b, m_rr);
        chk("gnt_a", gnt_a, g[1]);
        chk("gnt_b", gnt_b, g[0]);
        chk("we1", we1, g[1] && we_a);
        chk("oe1", oe1, g[1] && !we_a);
        chk("we2", we2, g[0] && we_b);
        chk("oe2", oe2, g[0] && !we_b);
        chk("addr1", addr1, addr_a);
        chk("addr2", addr2, addr_b);
        chk("d_in1", d_in1, wdata_a);
        chk("d_in2", d_in2, wdata_b);
        chk("rvalid_a", rvalid_a, m_rva);
        chk("rvalid_b", rvalid_b, m_rvb);
        if (m_rva) chk("rdata_a", rdata_a, m_rda);
        if (m_rvb) chk("rdata_b", rdata_b, m_rdb);
        chk("stall_cnt_a", stall_cnt_a, m_sa);
        chk("stall_cnt_b", stall_cnt_b, m_sb);
        chk("port_clash", ((we1 && (we2 || oe2)) || (we2 && oe1)) && addr1 == addr2, 0);
    end

    task automatic step(input logic ra, input logic wa, input int aa, input int da,
                        input logic rb, input logic wb, input int ab, input int db);
        @(posedge clk);
        #1;
        req_a = ra; we_a = wa; addr_a = 4'(aa); wdata_a = 2'(da);
        req_b = rb; we_b = wb; addr_b = 4'(ab); wdata_b = 2'(db);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_a = 0; we_a = 0; req_b = 0; we_b = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 0;
        req_b = 1; we_b = 0; addr_b = 0; wdata_b = 0;
        @(negedge clk);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_we1", we1, 0);
        chk("rst_oe2", oe2, 0);
        chk("rst_stall_a", stall_cnt_a, 0);
        chk("rst_rvalid_b", rvalid_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload every address so later reads are defined.
        for (int i = 0; i < 8; i++) step(1, 1, i, i % 4, 1, 1, i + 8, (i + 1) % 4);

        // Write/read conflict: A wins first, B follows and reads the new data.
        do_reset();
        step(1, 1, 3, 2, 1, 0, 3, 0);
        chk("wr_conf_gnt_a", gnt_a, 1);
        chk("wr_conf_gnt_b", gnt_b, 0);
        step(0, 0, 0, 0, 1, 0, 3, 0);
        chk("wr_conf_stall_b", stall_cnt_b, 1);
        chk("wr_conf_gnt_b2", gnt_b, 1);
        idle();
        chk("wr_conf_rvalid_b", rvalid_b, 1);
        chk("wr_conf_rdata_b", rdata_b, 2);

        // Write-write conflict alternates and the deferred write lands last.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 5, 1, 1, 1, 5, 2);
            chk("ww_gnt_a", gnt_a, (k % 2 == 0) ? 1 : 0);
            chk("ww_gnt_b", gnt_b, (k % 2 == 1) ? 1 : 0);
        end
        idle();
        chk("ww_stall_a", stall_cnt_a, 2);
        chk("ww_stall_b", stall_cnt_b, 2);
        step(1, 0, 5, 0, 0, 0, 0, 0);
        idle();
        chk("ww_final_rvalid", rvalid_a, 1);
        chk("ww_final_data", rdata_a, 2);

        // Same-address reads are both granted.
        step(1, 1, 7, 3, 0, 0, 0, 0);
        step(1, 0, 7, 0, 1, 0, 7, 0);
        chk("rr_gnt_a", gnt_a, 1);
        chk("rr_gnt_b", gnt_b, 1);
        idle();
        chk("rr_rvalid_a", rvalid_a, 1);
        chk("rr_rvalid_b", rvalid_b, 1);
        chk("rr_rdata_a", rdata_a, 3);
        chk("rr_rdata_b", rdata_b, 3);

        // Saturation: 600 conflicts, each client loses 300.
        do_reset();
        for (int n = 0; n < 20; n++) step(1, 1, 9, 1, 1, 0, 9, 0);
        idle();
        chk("sat_mid_a", stall_cnt_a, 10);
        chk("sat_mid_b", stall_cnt_b, 10);
        for (int n = 0; n < 580; n++) step(1, 1, 9, 1, 1, 0, 9, 0);
        idle();
        chk("sat_a", stall_cnt_a, 255);
        chk("sat_b", stall_cnt_b, 255);

        // Reset with a read in flight.
        do_reset();
        chk("post_rst_stall_b", stall_cnt_b, 0);
        step(1, 0, 2, 0, 0, 0, 0, 0);
        chk("inflight_gnt_a", gnt_a, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_a = 1; we_a = 1; addr_a = 4; req_b = 1; we_b = 1; addr_b = 4;
        @(negedge clk);
        chk("inrst_gnt_a", gnt_a, 0);
        chk("inrst_gnt_b", gnt_b, 0);
        chk("inrst_rvalid_a", rvalid_a, 0);
        chk("inrst_we2", we2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_a = 0; req_b = 0;
        @(negedge clk);
        chk("rel_rvalid_a", rvalid_a, 0);
        idle();
        chk("rel_rvalid_a2", rvalid_a, 0);
        step(1, 1, 4, 1, 1, 1, 4, 2);
        chk("rel_first_gnt_a", gnt_a, 1);
        chk("rel_first_gnt_b", gnt_b, 0);

        // Random non-conflicting traffic.
        for (int n = 0; n < 60; n++) begin
            logic ra, wa, rb, wb;
            int   aa, ab;
            ra = 1'($urandom_range(0, 1));
            wa = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            aa = int'($urandom_range(0, 15));
            ab = (aa + int'($urandom_range(1, 15))) % 16;
            step(ra, wa, aa, int'($urandom_range(0, 3)), rb, wb, ab, int'($urandom_range(0, 3)));
            chk("rnd_gnt_a", gnt_a, ra);
            chk("rnd_gnt_b", gnt_b, rb);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
